fetch_stage: RTL and testbench

- Instruction-fetch stage of the 16-bit 5-stage pipeline; sits directly upstream of instruction decode and drives the IF/ID pipeline register.
- Owns the PC, issues word-addressed requests to instruction memory over a req/ack handshake, and honours decode stalls and EX-stage redirects (branch/JAL/JR).
- Detects HLT at fetch and parks until redirected.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_stage_hold_buf.sv | 34 +++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: widths, encodings, fetch FSM states
// and the IF/ID pipeline register layout.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam logic [3:0] HLT_OPCODE = 4'hF;
    localparam instr_t     NOP        = 16'h0000;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc_plus1;
        logic   valid;
    } if_id_t;

    function automatic logic is_hlt(input instr_t instr, input logic [3:0] op);
        return instr[INSTR_W-1 -: 4] == op;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge channel between fetch and imem.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic   imem_req;
    addr_t  imem_addr;
    logic   imem_ack;
    instr_t imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_stage_hold_buf.sv
// Single-entry skid buffer that parks a fetched instruction while decode is stalled.
module if_hold_buf
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   clear,
    input  instr_t d_instr,
    input  addr_t  d_pc_plus1,
    output logic   full,
    output instr_t instr,
    output addr_t  pc_plus1
);

    if_id_t q;

    // NOTE: one entry only, so the payload is reset with the flag; a deeper
    // buffer would reset just its occupancy and leave the storage array alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '{instr: NOP, pc_plus1: '0, valid: 1'b0};
        end else if (clear) begin
            q.valid <= 1'b0;
        end else if (load) begin
            q <= '{instr: d_instr, pc_plus1: d_pc_plus1, valid: 1'b1};
        end
    end

    assign full     = q.valid;
    assign instr    = q.instr;
    assign pc_plus1 = q.pc_plus1;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack channel, honours
// decode stalls and EX redirects, and parks on HLT until redirected.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter addr_t      RESET_PC = 16'h0000,
    parameter logic [3:0] HLT_OP   = cpu_pkg::HLT_OPCODE
)
(
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master imem,
    input  logic          stall_ID,
    input  logic          redirect_EX,
    input  addr_t         redirect_pc_EX,
    output instr_t        instr_IF_ID,
    output addr_t         pc_plus1_IF_ID,
    output logic          valid_IF_ID,
    output logic          hlt_IF,
    output addr_t         pc
);

    fetch_state_t state, state_next;
    if_id_t       if_id;
    logic         drop_pending;
    addr_t        drop_addr;

    logic   fetch_hit, take_mem, buf_load, buf_release, buf_clear, buf_full;
    instr_t buf_instr;
    addr_t  buf_pc_plus1;

    // A returning ack only counts if it is not the stale response of a redirected request.
    assign fetch_hit = imem.imem_ack && !drop_pending;

    if_hold_buf u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .clear      (buf_clear),
        .d_instr    (imem.imem_rdata),
        .d_pc_plus1 (pc + addr_t'(1)),
        .full       (buf_full),
        .instr      (buf_instr),
        .pc_plus1   (buf_pc_plus1)
    );

    // NOTE: non-blocking so every register samples pre-edge values whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    // NOTE: defaults first, so no path through the comb blocks can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH:   if (fetch_hit)
                         state_next = stall_ID ? HOLD
                                    : (is_hlt(imem.imem_rdata, HLT_OP) ? HALTED : FETCH);
            HOLD:    if (!stall_ID && buf_full)
                         state_next = is_hlt(buf_instr, HLT_OP) ? HALTED : FETCH;
            HALTED:  state_next = HALTED;
            default: state_next = FETCH;
        endcase
        if (redirect_EX) state_next = FETCH;
    end

    always_comb begin
        imem.imem_req  = rst_n && (state == FETCH);
        imem.imem_addr = drop_pending ? drop_addr : pc;
        take_mem       = (state == FETCH) && fetch_hit && !redirect_EX && !stall_ID;
        buf_load       = (state == FETCH) && fetch_hit && !redirect_EX &&  stall_ID;
        buf_release    = (state == HOLD) && buf_full && !stall_ID && !redirect_EX;
        buf_clear      = redirect_EX || buf_release;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            if_id        <= '{instr: NOP, pc_plus1: '0, valid: 1'b0};
            hlt_IF       <= 1'b0;
            drop_pending <= 1'b0;
            drop_addr    <= RESET_PC;
        end else if (redirect_EX) begin
            pc           <= redirect_pc_EX;
            if_id.valid  <= 1'b0;
            hlt_IF       <= 1'b0;
            // An unanswered request must finish at its original address before the new one goes out.
            drop_pending <= (state == FETCH) && !imem.imem_ack;
            if ((state == FETCH) && !imem.imem_ack && !drop_pending)
                drop_addr <= pc;
        end else begin
            if (drop_pending && imem.imem_ack)
                drop_pending <= 1'b0;
            if (take_mem) begin
                if_id  <= '{instr: imem.imem_rdata, pc_plus1: pc + addr_t'(1), valid: 1'b1};
                pc     <= pc + addr_t'(1);
                hlt_IF <= is_hlt(imem.imem_rdata, HLT_OP);
            end else if (buf_release) begin
                if_id  <= '{instr: buf_instr, pc_plus1: buf_pc_plus1, valid: 1'b1};
                pc     <= buf_pc_plus1;
                hlt_IF <= is_hlt(buf_instr, HLT_OP);
            end else if (!stall_ID) begin
                if_id.valid <= 1'b0;
            end
        end
    end

    assign instr_IF_ID    = if_id.instr;
    assign pc_plus1_IF_ID = if_id.pc_plus1;
    assign valid_IF_ID    = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table-driven per-cycle vectors plus hand-written
// sequences for wait states, redirect-while-outstanding, halt and async reset.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   stall_ID = 1'b0;
    logic   redirect_EX = 1'b0;
    addr_t  redirect_pc_EX = '0;
    instr_t instr_IF_ID;
    addr_t  pc_plus1_IF_ID;
    logic   valid_IF_ID;
    logic   hlt_IF;
    addr_t  pc;

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus),
        .stall_ID       (stall_ID),
        .redirect_EX    (redirect_EX),
        .redirect_pc_EX (redirect_pc_EX),
        .instr_IF_ID    (instr_IF_ID),
        .pc_plus1_IF_ID (pc_plus1_IF_ID),
        .valid_IF_ID    (valid_IF_ID),
        .hlt_IF         (hlt_IF),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    // Instruction memory: acks once a request has waited ack_delay cycles (0 = same cycle).
    instr_t mem [256];
    int     ack_delay = 0;
    int     wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= 0;
        else if (imem_bus.imem_req && !imem_bus.imem_ack)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    assign imem_bus.imem_ack   = imem_bus.imem_req && (wait_cnt >= ack_delay);
    assign imem_bus.imem_rdata = mem[imem_bus.imem_addr[7:0]];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic   stall;
        logic   redir;
        addr_t  rpc;
        logic   exp_req;
        addr_t  exp_addr;
        logic   exp_valid;
        instr_t exp_instr;
        addr_t  exp_pcp1;
        addr_t  exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input addr_t rpc,
                                input logic req, input addr_t addr, input logic v,
                                input instr_t ins, input addr_t p1, input addr_t pcv);
        vec_t t;
        t = '{stall: s, redir: r, rpc: rpc, exp_req: req, exp_addr: addr,
              exp_valid: v, exp_instr: ins, exp_pcp1: p1, exp_pc: pcv};
        return t;
    endfunction

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | instr_t'(i);
        mem[8'h00] = 16'h1111;
        mem[8'h01] = 16'h2222;
        mem[8'h02] = 16'h3333;
        mem[8'h08] = 16'hABCD;
        mem[8'h20] = 16'hF000;

        // Expected values observed at the negedge following each vector's clock edge.
        //              stall redir rpc      req addr     v  instr     pc+1     pc
        vecs[0]  = mk(0, 0, 16'h0000, 1, 16'h0001, 1, 16'h1111, 16'h0001, 16'h0001);
        vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h0002, 1, 16'h2222, 16'h0002, 16'h0002);
        vecs[2]  = mk(0, 0, 16'h0000, 1, 16'h0003, 1, 16'h3333, 16'h0003, 16'h0003);
        vecs[3]  = mk(0, 0, 16'h0000, 1, 16'h0004, 1, 16'h1003, 16'h0004, 16'h0004);
        vecs[4]  = mk(0, 1, 16'h0010, 1, 16'h0010, 0, 16'h0000, 16'h0000, 16'h0010);
        vecs[5]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0010);
        vecs[6]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0010);
        vecs[7]  = mk(0, 0, 16'h0000, 1, 16'h0011, 1, 16'h1010, 16'h0011, 16'h0011);
        vecs[8]  = mk(0, 0, 16'h0000, 1, 16'h0012, 1, 16'h1011, 16'h0012, 16'h0012);
        vecs[9]  = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h1011, 16'h0012, 16'h0012);
        vecs[10] = mk(0, 0, 16'h0000, 1, 16'h0013, 1, 16'h1012, 16'h0013, 16'h0013);
        vecs[11] = mk(0, 1, 16'hFFFF, 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'hFFFF);
        vecs[12] = mk(0, 0, 16'h0000, 1, 16'h0000, 1, 16'h10FF, 16'h0000, 16'h0000);
        vecs[13] = mk(0, 0, 16'h0000, 1, 16'h0001, 1, 16'h1111, 16'h0001, 16'h0001);
        vecs[14] = mk(1, 1, 16'h0010, 1, 16'h0010, 0, 16'h0000, 16'h0000, 16'h0010);
        vecs[15] = mk(0, 0, 16'h0000, 1, 16'h0011, 1, 16'h1010, 16'h0011, 16'h0011);

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        check("rst req",   imem_bus.imem_req, 1'b0);
        check("rst valid", valid_IF_ID, 1'b0);
        check("rst instr", instr_IF_ID, 16'h0000);
        check("rst pcp1",  pc_plus1_IF_ID, 16'h0000);
        check("rst hlt",   hlt_IF, 1'b0);
        check("rst pc",    pc, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("post-rst req",  imem_bus.imem_req, 1'b1);
        check("post-rst addr", imem_bus.imem_addr, 16'h0000);

        for (int i = 0; i < NV; i++) begin
            stall_ID       = vecs[i].stall;
            redirect_EX    = vecs[i].redir;
            redirect_pc_EX = vecs[i].rpc;
            cycle();
            check($sformatf("v%0d req", i), imem_bus.imem_req, vecs[i].exp_req);
            if (vecs[i].exp_req)
                check($sformatf("v%0d addr", i), imem_bus.imem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d valid", i), valid_IF_ID, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d instr", i), instr_IF_ID, vecs[i].exp_instr);
                check($sformatf("v%0d pcp1", i), pc_plus1_IF_ID, vecs[i].exp_pcp1);
            end
            check($sformatf("v%0d hlt", i), hlt_IF, 1'b0);
            check($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
        end
        stall_ID    = 1'b0;
        redirect_EX = 1'b0;

        // Three wait states on address 0x0005.
        redirect_EX = 1'b1; redirect_pc_EX = 16'h0005;
        cycle();
        redirect_EX = 1'b0;
        ack_delay   = 3;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wait%0d req", k),  imem_bus.imem_req, 1'b1);
            check($sformatf("wait%0d addr", k), imem_bus.imem_addr, 16'h0005);
            cycle();
            check($sformatf("wait%0d valid", k), valid_IF_ID, (k == 3));
        end
        check("wait instr", instr_IF_ID, 16'h1005);
        check("wait pcp1",  pc_plus1_IF_ID, 16'h0006);
        ack_delay = 0;

        // Redirect to 0x0040 while the request to 0x0008 is still outstanding.
        redirect_EX = 1'b1; redirect_pc_EX = 16'h0008;
        cycle();
        check("drop addr8", imem_bus.imem_addr, 16'h0008);
        ack_delay   = 2;
        redirect_pc_EX = 16'h0040;
        cycle();
        redirect_EX = 1'b0;
        check("drop d1 addr",  imem_bus.imem_addr, 16'h0008);
        check("drop d1 valid", valid_IF_ID, 1'b0);
        check("drop d1 pc",    pc, 16'h0040);
        cycle();
        check("drop d2 addr",  imem_bus.imem_addr, 16'h0008);
        check("drop d2 valid", valid_IF_ID, 1'b0);
        cycle();
        check("drop d3 addr",  imem_bus.imem_addr, 16'h0040);
        check("drop d3 valid", valid_IF_ID, 1'b0);
        ack_delay = 0;
        cycle();
        check("drop new valid", valid_IF_ID, 1'b1);
        check("drop new instr", instr_IF_ID, 16'h1040);
        check("drop new pcp1",  pc_plus1_IF_ID, 16'h0041);

        // HLT at 0x0020, park, then redirect out to 0x0030.
        redirect_EX = 1'b1; redirect_pc_EX = 16'h0020;
        cycle();
        redirect_EX = 1'b0;
        check("hlt addr", imem_bus.imem_addr, 16'h0020);
        cycle();
        check("hlt flag",  hlt_IF, 1'b1);
        check("hlt valid", valid_IF_ID, 1'b1);
        check("hlt instr", instr_IF_ID, 16'hF000);
        check("hlt pcp1",  pc_plus1_IF_ID, 16'h0021);
        check("hlt pc",    pc, 16'h0021);
        check("hlt req",   imem_bus.imem_req, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            check($sformatf("parked%0d req", k), imem_bus.imem_req, 1'b0);
            check($sformatf("parked%0d hlt", k), hlt_IF, 1'b1);
        end
        redirect_EX = 1'b1; redirect_pc_EX = 16'h0030;
        cycle();
        redirect_EX = 1'b0;
        check("unpark hlt",   hlt_IF, 1'b0);
        check("unpark req",   imem_bus.imem_req, 1'b1);
        check("unpark addr",  imem_bus.imem_addr, 16'h0030);
        check("unpark valid", valid_IF_ID, 1'b0);
        cycle();
        check("unpark instr", instr_IF_ID, 16'h1030);
        check("unpark v",     valid_IF_ID, 1'b1);

        // Asynchronous reset in the middle of HOLD with a live IF/ID.
        stall_ID = 1'b1;
        cycle();
        check("hold req",   imem_bus.imem_req, 1'b0);
        check("hold valid", valid_IF_ID, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst req",   imem_bus.imem_req, 1'b0);
        check("arst valid", valid_IF_ID, 1'b0);
        check("arst instr", instr_IF_ID, 16'h0000);
        check("arst pcp1",  pc_plus1_IF_ID, 16'h0000);
        check("arst hlt",   hlt_IF, 1'b0);
        check("arst pc",    pc, 16'h0000);
        stall_ID = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rerst req",  imem_bus.imem_req, 1'b1);
        check("rerst addr", imem_bus.imem_addr, 16'h0000);
        cycle();
        check("rerst instr", instr_IF_ID, 16'h1111);
        check("rerst pcp1",  pc_plus1_IF_ID, 16'h0001);
        check("rerst valid", valid_IF_ID, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
